// File: rtl/button_repeat_if.sv
// button_repeat_if: button key-event bundle; tick/in toward the block, press/rel/step/held back
interface button_repeat_if;
  logic tick;
  logic in;
  logic press;
  logic rel;
  logic step;
  logic held;
  modport master(output tick, in, input press, rel, step, held);
  modport slave(input tick, in, output press, rel, step, held);
endinterface

// File: rtl/button_repeat.sv
// button_repeat: debounced level to press/rel/step pulses plus held level, tick-timed auto-repeat; ports clk, reset, b(slave)
module button_repeat #(
  parameter int DELAY_TICKS  = 500,
  parameter int REPEAT_TICKS = 100,
  parameter int ACCEL_STEPS  = 8,
  parameter int FAST_TICKS   = 25,
  parameter int CNT_W        = 16
) (
  input logic clk,
  input logic reset,
  button_repeat_if.slave b
);
  localparam int REP_W = $clog2(ACCEL_STEPS + 2);
  localparam logic [CNT_W-1:0] DLY = CNT_W'(DELAY_TICKS - 1);
  localparam logic [CNT_W-1:0] SLOW = CNT_W'(REPEAT_TICKS - 1);
  localparam logic [CNT_W-1:0] FAST = CNT_W'(FAST_TICKS - 1);
  localparam logic [REP_W-1:0] ACC = REP_W'(ACCEL_STEPS);
  typedef enum logic [1:0] {IDLE, WAIT, REPEAT} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, per;
  logic [REP_W-1:0] rep_q, rep_d;
  logic press_q, press_d, rel_q, rel_d, step_q, step_d, held_q, held_d;
  assign per = (rep_q < ACC) ? SLOW : FAST;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    rep_d = rep_q;
    press_d = 1'b0;
    rel_d = 1'b0;
    step_d = 1'b0;
    held_d = held_q;
    case (state_q)
      IDLE: if (b.in) begin
        press_d = 1'b1;
        step_d = 1'b1;
        cnt_d = '0;
        rep_d = '0;
        state_d = WAIT;
      end
      WAIT: if (!b.in) begin
        rel_d = 1'b1;
        cnt_d = '0;
        state_d = IDLE;
      end else if (b.tick) begin
        step_d = cnt_q == DLY;
        held_d = cnt_q == DLY;
        cnt_d = (cnt_q == DLY) ? '0 : cnt_q + CNT_W'(1);
        state_d = (cnt_q == DLY) ? REPEAT : WAIT;
      end
      REPEAT: if (!b.in) begin
        rel_d = 1'b1;
        held_d = 1'b0;
        cnt_d = '0;
        state_d = IDLE;
      end else if (b.tick) begin
        step_d = cnt_q == per;
        cnt_d = (cnt_q == per) ? '0 : cnt_q + CNT_W'(1);
        rep_d = (cnt_q == per && rep_q != ACC) ? rep_q + REP_W'(1) : rep_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rep_q <= '0;
      press_q <= 1'b0;
      rel_q <= 1'b0;
      step_q <= 1'b0;
      held_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rep_q <= rep_d;
      press_q <= press_d;
      rel_q <= rel_d;
      step_q <= step_d;
      held_q <= held_d;
    end
  end
  assign b.press = press_q;
  assign b.rel = rel_q;
  assign b.step = step_q;
  assign b.held = held_q;
endmodule

// File: tb/tb_button_repeat.sv
// tb_button_repeat: table, corner-case and random checks of button_repeat against a tick-count schedule model
module tb_button_repeat;
  localparam int D = 4, R = 3, A = 2, F = 1;
  typedef struct packed {
    logic r, i, t;
    logic [3:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic reset;
  int checks = 0, errors = 0;
  logic mp = 1'b0, ep, erl, es, eh;
  int mn = 0;
  vec_t tv[$];
  logic cur_in;
  button_repeat_if b();
  button_repeat #(.DELAY_TICKS(D), .REPEAT_TICKS(R), .ACCEL_STEPS(A), .FAST_TICKS(F), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .b(b)
  );
  always #5 clk = ~clk;
  function automatic bit is_step(int n);
    int k;
    if (n < D) return 1'b0;
    k = n - D;
    return (k <= A * R) ? (k % R == 0) : ((k - A * R) % F == 0);
  endfunction
  function automatic logic [3:0] outs();
    return {b.press, b.rel, b.step, b.held};
  endfunction
  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got press/rel/step/held=%b want %b at %0t", name, got, want, $time);
    end
  endtask
  task automatic apply(input logic r, input logic i, input logic t);
    reset = r;
    b.in = i;
    b.tick = t;
    {ep, erl, es} = 3'b000;
    if (r) begin
      mp = 1'b0;
      mn = 0;
      eh = 1'b0;
    end else if (!mp) begin
      if (i) begin
        mp = 1'b1;
        mn = 0;
        ep = 1'b1;
        es = 1'b1;
      end
    end else if (!i) begin
      mp = 1'b0;
      erl = 1'b1;
      eh = 1'b0;
    end else if (t) begin
      mn++;
      es = is_step(mn);
      eh = mn >= D;
    end
    @(posedge clk);
    #1;
    check("model", outs(), {ep, erl, es, eh});
  endtask
  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) apply(1'b0, 1'b1, 1'b1);
  endtask
  task automatic add(input logic r, input logic i, input logic t, input logic [3:0] e);
    tv.push_back('{r: r, i: i, t: t, exp: e});
  endtask
  initial begin
    add(1, 0, 0, 4'b0000);
    add(0, 1, 0, 4'b1010);
    add(0, 1, 1, 4'b0000);
    add(0, 1, 1, 4'b0000);
    add(0, 1, 1, 4'b0000);
    add(0, 0, 0, 4'b0100);
    add(0, 0, 1, 4'b0000);
    add(0, 0, 1, 4'b0000);
    add(0, 1, 1, 4'b1010);
    add(0, 1, 1, 4'b0000);
    add(0, 1, 1, 4'b0000);
    add(0, 1, 1, 4'b0000);
    add(0, 1, 1, 4'b0011);
    add(0, 1, 1, 4'b0001);
    add(0, 1, 1, 4'b0001);
    add(0, 1, 1, 4'b0011);
    add(0, 1, 1, 4'b0001);
    add(0, 1, 1, 4'b0001);
    add(0, 1, 1, 4'b0011);
    add(0, 1, 1, 4'b0011);
    add(0, 1, 1, 4'b0011);
    add(0, 0, 1, 4'b0100);
    reset = 1'b1;
    b.in = 1'b0;
    b.tick = 1'b0;
    foreach (tv[k]) begin
      apply(tv[k].r, tv[k].i, tv[k].t);
      check($sformatf("table[%0d]", k), outs(), tv[k].exp);
    end
    apply(0, 1, 0);
    ticks(15);
    apply(0, 0, 1);
    check("rel_wins", outs(), 4'b0100);
    apply(0, 0, 0);
    check("idle_after_rel", outs(), 4'b0000);
    apply(0, 1, 0);
    ticks(6);
    apply(1, 1, 1);
    check("reset_mid_hold", outs(), 4'b0000);
    apply(0, 1, 0);
    check("repress_after_reset", outs(), 4'b1010);
    ticks(5);
    for (int k = 0; k < 1000; k++) apply(0, 1, 0);
    check("stall_held", outs(), 4'b0001);
    apply(0, 1, 1);
    check("resume1", outs(), 4'b0001);
    apply(0, 1, 1);
    check("resume2", outs(), 4'b0011);
    apply(0, 0, 0);
    check("release2", outs(), 4'b0100);
    apply(0, 1, 1);
    check("second_press", outs(), 4'b1010);
    ticks(3);
    check("no_early_step", outs(), 4'b0000);
    ticks(1);
    check("redelay", outs(), 4'b0011);
    ticks(1);
    check("slow_again", outs(), 4'b0001);
    ticks(2);
    check("slow_step", outs(), 4'b0011);
    cur_in = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(29) == 0) cur_in = ~cur_in;
      apply($urandom_range(199) == 0, cur_in, (k % 800 < 200) ? 1'b1 : 1'($urandom_range(1)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
